// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass and load-use hazard detection; 1-cycle latency.
// Backpressure: a combinational stall holds PC and IF/ID for one cycle while a bubble enters EX.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  input  logic              wb_write_en,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
  } ex_reg_t;

  ex_reg_t           ex_q;
  ex_reg_t           ex_d;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              haz;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt_q;

  always_comb begin
    a_in = id_rd1;
    b_in = id_rd2;
    // r0 is hardwired zero, so a write to it must never be forwarded
    if (wb_write_en && (wb_dest != 5'd0) && (wb_dest == id_rs)) a_in = wb_data;
    if (wb_write_en && (wb_dest != 5'd0) && (wb_dest == id_rt)) b_in = wb_data;

    haz = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != 5'd0) &&
          ((ex_q.dest == id_rs) || (id_uses_rt && (ex_q.dest == id_rt)));
    // a taken branch squashes the consumer anyway, so IF/ID must keep refilling
    stall  = haz && !flush;
    bubble = flush || stall || !id_valid;

    ex_d            = '0;
    ex_d.valid      = 1'b1;
    ex_d.pc4        = id_pc4;
    ex_d.imm        = id_imm;
    ex_d.a          = a_in;
    ex_d.b          = b_in;
    ex_d.rs         = id_rs;
    ex_d.rt         = id_rt;
    ex_d.dest       = id_reg_dst ? id_rd : id_rt;
    ex_d.reg_write  = id_reg_write;
    ex_d.mem_read   = id_mem_read;
    ex_d.mem_write  = id_mem_write;
    ex_d.mem_to_reg = id_mem_to_reg;
    ex_d.alu_src    = id_alu_src;
    ex_d.alu_op     = id_alu_op;
  end

  always_ff @(posedge clk) begin
    if (reset)       ex_q <= '0;
    else if (bubble) ex_q <= '0;
    else             ex_q <= ex_d;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != '1))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc4        = ex_q.pc4;
  assign ex_imm        = ex_q.imm;
  assign ex_a          = ex_q.a;
  assign ex_b          = ex_q.b;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dest       = ex_q.dest;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
  assign stall_count   = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: single-cycle vector table plus load-use, flush and saturation sequences.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [DW-1:0] id_pc4, id_imm, id_rd1, id_rd2, wb_data;
  logic [4:0]    id_rs, id_rt, id_rd, wb_dest;
  logic          id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
  logic          id_mem_to_reg, id_alu_src, id_reg_dst, wb_write_en, flush;
  logic [3:0]    id_alu_op;
  logic          stall, ex_valid;
  logic [DW-1:0] ex_pc4, ex_imm, ex_a, ex_b;
  logic [4:0]    ex_rs, ex_rt, ex_dest;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]    ex_alu_op;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc4(id_pc4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_imm(id_imm), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_op(id_alu_op),
    .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_pc4(ex_pc4),
    .ex_imm(ex_imm), .ex_a(ex_a), .ex_b(ex_b), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst}; e_ctl drops reg_dst
  typedef struct {
    logic          vld;
    logic [DW-1:0] pc4, imm, rd1, rd2;
    logic [4:0]    rs, rt, rd;
    logic          uses_rt;
    logic [5:0]    ctl;
    logic [3:0]    op;
    logic          wb_en;
    logic [4:0]    wb_dst;
    logic [DW-1:0] wb_dat;
    logic          fl;
    logic          e_vld;
    logic [DW-1:0] e_a, e_b, e_pc4, e_imm;
    logic [4:0]    e_rs, e_rt, e_dest;
    logic [4:0]    e_ctl;
    logic [3:0]    e_op;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    id_valid = 0; id_pc4 = 0; id_imm = 0; id_rd1 = 0; id_rd2 = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst} = 6'b0;
    id_alu_op = 0; wb_write_en = 0; wb_dest = 0; wb_data = 0; flush = 0;
  endtask

  // producer load: lw $7 <- ..., rt destination
  task automatic drive_load7();
    drive_idle();
    id_valid = 1; id_rs = 5'd2; id_rt = 5'd7; id_rd = 5'd0; id_uses_rt = 0;
    id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1; id_alu_src = 1; id_reg_dst = 0;
    id_rd1 = 32'h1000; id_imm = 32'h4;
  endtask

  task automatic drive_consumer(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt);
    drive_idle();
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = 5'd8; id_uses_rt = uses_rt;
    id_reg_write = 1; id_reg_dst = 1; id_rd1 = 32'h50; id_rd2 = 32'h60; id_alu_op = 4'd2;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h104, 32'h10, 32'hA, 32'hB, 5'd3, 5'd4, 5'd5, 1'b1, 6'b100001, 4'd2,
                1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'hA, 32'hB, 32'h104, 32'h10, 5'd3, 5'd4, 5'd5, 5'b10000, 4'd2};
    vecs[1] = '{1'b1, 32'h108, 32'h20, 32'h1, 32'h2, 5'd3, 5'd6, 5'd1, 1'b1, 6'b100000, 4'd1,
                1'b1, 5'd3, 32'hDEAD, 1'b0,
                1'b1, 32'hDEAD, 32'h2, 32'h108, 32'h20, 5'd3, 5'd6, 5'd6, 5'b10000, 4'd1};
    vecs[2] = '{1'b1, 32'h10C, 32'h0, 32'h1, 32'h5, 5'd0, 5'd0, 5'd2, 1'b1, 6'b000000, 4'd0,
                1'b1, 5'd0, 32'hDEAD, 1'b0,
                1'b1, 32'h1, 32'h5, 32'h10C, 32'h0, 5'd0, 5'd0, 5'd0, 5'b00000, 4'd0};
    vecs[3] = '{1'b1, 32'h110, 32'h4, 32'h11, 32'h22, 5'd8, 5'd9, 5'd10, 1'b1, 6'b100000, 4'd3,
                1'b1, 5'd9, 32'h77, 1'b0,
                1'b1, 32'h11, 32'h77, 32'h110, 32'h4, 5'd8, 5'd9, 5'd9, 5'b10000, 4'd3};
    vecs[4] = '{1'b1, 32'h114, 32'h8, 32'h33, 32'h44, 5'd3, 5'd3, 5'd7, 1'b1, 6'b100001, 4'd4,
                1'b0, 5'd3, 32'hBEEF, 1'b0,
                1'b1, 32'h33, 32'h44, 32'h114, 32'h8, 5'd3, 5'd3, 5'd7, 5'b10000, 4'd4};
    vecs[5] = '{1'b0, 32'h118, 32'hC, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3, 1'b1, 6'b111111, 4'd5,
                1'b0, 5'd0, 32'h0, 1'b0,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'b00000, 4'd0};
    vecs[6] = '{1'b1, 32'h11C, 32'hF, 32'h55, 32'h66, 5'd1, 5'd2, 5'd3, 1'b1, 6'b101111, 4'd6,
                1'b1, 5'd1, 32'h99, 1'b1,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'b00000, 4'd0};
    vecs[7] = '{1'b1, 32'h120, 32'hFFFF_FFFF, 32'h7, 32'h8, 5'd30, 5'd29, 5'd31, 1'b0, 6'b101111, 4'hF,
                1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'h7, 32'h8, 32'h120, 32'hFFFF_FFFF, 5'd30, 5'd29, 5'd31, 5'b10111, 4'hF};
    vecs[8] = '{1'b1, 32'h124, 32'h4, 32'h100, 32'h0, 5'd29, 5'd12, 5'd0, 1'b1, 6'b110110, 4'd0,
                1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 32'h100, 32'h0, 32'h124, 32'h4, 5'd29, 5'd12, 5'd12, 5'b11011, 4'd0};

    // reset with a live instruction on the inputs
    drive_idle();
    reset = 1; id_valid = 1; id_rd1 = 32'h1234; id_rs = 5'd3;
    tick();
    reset = 0;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_ex_a", ex_a, 32'h0);
    chk("rst_ex_ctl", {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src}, 32'h0);
    chk("rst_ex_dest", {27'b0, ex_dest}, 32'h0);
    chk("rst_stall_count", {28'b0, stall_count}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      id_valid = vecs[i].vld; id_pc4 = vecs[i].pc4; id_imm = vecs[i].imm;
      id_rd1 = vecs[i].rd1; id_rd2 = vecs[i].rd2;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd; id_uses_rt = vecs[i].uses_rt;
      {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst} = vecs[i].ctl;
      id_alu_op = vecs[i].op; wb_write_en = vecs[i].wb_en; wb_dest = vecs[i].wb_dst;
      wb_data = vecs[i].wb_dat; flush = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
      tick();
      chk($sformatf("v%0d_ex_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_vld});
      chk($sformatf("v%0d_ex_a", i), ex_a, vecs[i].e_a);
      chk($sformatf("v%0d_ex_b", i), ex_b, vecs[i].e_b);
      chk($sformatf("v%0d_ex_pc4", i), ex_pc4, vecs[i].e_pc4);
      chk($sformatf("v%0d_ex_imm", i), ex_imm, vecs[i].e_imm);
      chk($sformatf("v%0d_ex_rs", i), {27'b0, ex_rs}, {27'b0, vecs[i].e_rs});
      chk($sformatf("v%0d_ex_rt", i), {27'b0, ex_rt}, {27'b0, vecs[i].e_rt});
      chk($sformatf("v%0d_ex_dest", i), {27'b0, ex_dest}, {27'b0, vecs[i].e_dest});
      chk($sformatf("v%0d_ex_ctl", i),
          {27'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src},
          {27'b0, vecs[i].e_ctl});
      chk($sformatf("v%0d_ex_alu_op", i), {28'b0, ex_alu_op}, {28'b0, vecs[i].e_op});
    end
    drive_idle();
    tick();

    // load-use on rs, with a same-cycle writeback to the same register
    drive_load7();
    @(negedge clk); chk("lu_load_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("lu_load_mem_read", {31'b0, ex_mem_read}, 32'h1);
    chk("lu_load_dest", {27'b0, ex_dest}, 32'd7);
    drive_consumer(5'd7, 5'd3, 1'b1);
    wb_write_en = 1; wb_dest = 5'd7; wb_data = 32'hAAAA;
    @(negedge clk); chk("lu_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    chk("lu_bubble_a", ex_a, 32'h0);
    chk("lu_count1", {28'b0, stall_count}, 32'd1);
    wb_write_en = 0;
    @(negedge clk); chk("lu_retry_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("lu_retry_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_retry_a", ex_a, 32'h50);
    chk("lu_retry_dest", {27'b0, ex_dest}, 32'd8);
    chk("lu_retry_count", {28'b0, stall_count}, 32'd1);

    // consumer names rt=7 but does not read it
    drive_load7(); tick();
    drive_consumer(5'd2, 5'd7, 1'b0);
    @(negedge clk); chk("nort_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("nort_valid", {31'b0, ex_valid}, 32'h1);
    chk("nort_b", ex_b, 32'h60);
    chk("nort_count", {28'b0, stall_count}, 32'd1);

    // consumer reads rt=7
    drive_load7(); tick();
    drive_consumer(5'd2, 5'd7, 1'b1);
    @(negedge clk); chk("rt_stall", {31'b0, stall}, 32'h1);
    tick();
    chk("rt_bubble_valid", {31'b0, ex_valid}, 32'h0);
    chk("rt_count", {28'b0, stall_count}, 32'd2);

    // flush beats the hazard
    drive_load7(); tick();
    drive_consumer(5'd7, 5'd3, 1'b1);
    flush = 1;
    @(negedge clk); chk("fl_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("fl_valid", {31'b0, ex_valid}, 32'h0);
    chk("fl_count", {28'b0, stall_count}, 32'd2);

    // invalid ID slot never stalls
    drive_load7(); tick();
    drive_consumer(5'd7, 5'd7, 1'b1);
    id_valid = 0;
    @(negedge clk); chk("inv_stall", {31'b0, stall}, 32'h0);
    tick();
    chk("inv_count", {28'b0, stall_count}, 32'd2);

    // saturation: 20 more stalls on a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      int exp_cnt;
      drive_load7(); tick();
      drive_consumer(5'd7, 5'd3, 1'b1);
      @(negedge clk); chk($sformatf("sat%0d_stall", i), {31'b0, stall}, 32'h1);
      tick();
      exp_cnt = (3 + i > 15) ? 15 : 3 + i;
      chk($sformatf("sat%0d_count", i), {28'b0, stall_count}, exp_cnt[DW-1:0]);
    end

    // reset during a stall
    drive_load7(); tick();
    drive_consumer(5'd7, 5'd3, 1'b1);
    reset = 1;
    tick();
    reset = 0;
    chk("rststall_valid", {31'b0, ex_valid}, 32'h0);
    chk("rststall_mem_read", {31'b0, ex_mem_read}, 32'h0);
    chk("rststall_count", {28'b0, stall_count}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
